// File: rtl/bms_mon_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | bms_mon_pkg : FSM states, channel map and default thresholds for the BMS   |
// |               flag generator front end.                                    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package bms_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CH_CELL = 2'd0,
    CH_TEMP = 2'd1,
    CH_CUR  = 2'd2
  } ch_kind_t;

  localparam int DEF_N_CELLS     = 4;
  localparam int DEF_N_TEMP      = 2;
  localparam int DEF_ADC_W       = 12;
  localparam int DEF_SCAN_PERIOD = 10000;
  localparam int DEF_ACK_TMO     = 256;
  localparam int DEF_OV_SET      = 3686;
  localparam int DEF_OV_CLR      = 3563;
  localparam int DEF_UV_SET      = 2458;
  localparam int DEF_UV_CLR      = 2580;
  localparam int DEF_OT_SET      = 3000;
  localparam int DEF_OT_CLR      = 2800;
  localparam int DEF_UT_SET      = 800;
  localparam int DEF_UT_CLR      = 1000;
  localparam int DEF_OC_SET      = 1500;
  localparam int DEF_OC_CLR      = 1300;
  localparam int DEF_CHG_TH      = 50;

  // Cells first, then temperature sensors, pack current last.
  function automatic ch_kind_t chan_kind(input int idx,
                                         input int n_cells = DEF_N_CELLS,
                                         input int n_temp  = DEF_N_TEMP);
    if (idx < n_cells)
      return CH_CELL;
    else if (idx < n_cells + n_temp)
      return CH_TEMP;
    else
      return CH_CUR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bms_hyst_flag.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | bms_hyst_flag : single protection flag with set/clear hysteresis, updated  |
// |                 only on the scan commit strobe.                            |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module bms_hyst_flag (
  input  logic clk,
  input  logic rst_n,
  input  logic commit,
  input  logic set_cond,
  input  logic clr_cond,
  output logic flag
);

  logic flag_q;
  logic flag_d;

  always_comb begin
    flag_d = flag_q;
    if (commit) begin
      if (set_cond)
        flag_d = 1'b1;
      else if (clr_cond)
        flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flag_q <= 1'b0;
    else
      flag_q <= flag_d;
  end

  assign flag = flag_q;

endmodule
`default_nettype wire

// File: rtl/bms_flag_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | bms_flag_gen : scans cells/temps/current over an ADC req/ack handshake and |
// |                commits hysteretic ov/uv/ot/ut/oc flags at scan end.        |
// |                BMS_FLAG_MINMAX_EN adds registered per-scan min/max/I ports.|
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module bms_flag_gen
  import bms_mon_pkg::*;
#(
  parameter int N_CELLS     = DEF_N_CELLS,
  parameter int N_TEMP      = DEF_N_TEMP,
  parameter int ADC_W       = DEF_ADC_W,
  parameter int SCAN_PERIOD = DEF_SCAN_PERIOD,
  parameter int ACK_TMO     = DEF_ACK_TMO,
  parameter int OV_SET      = DEF_OV_SET,
  parameter int OV_CLR      = DEF_OV_CLR,
  parameter int UV_SET      = DEF_UV_SET,
  parameter int UV_CLR      = DEF_UV_CLR,
  parameter int OT_SET      = DEF_OT_SET,
  parameter int OT_CLR      = DEF_OT_CLR,
  parameter int UT_SET      = DEF_UT_SET,
  parameter int UT_CLR      = DEF_UT_CLR,
  parameter int OC_SET      = DEF_OC_SET,
  parameter int OC_CLR      = DEF_OC_CLR,
  parameter int CHG_TH      = DEF_CHG_TH,
  localparam int CH_W       = $clog2(N_CELLS + N_TEMP + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  output logic                    adc_req,
  output logic [CH_W-1:0]         adc_chan,
  input  logic                    adc_ack,
  input  logic [ADC_W-1:0]        adc_data,
  output logic                    ov_raw,
  output logic                    uv_raw,
  output logic                    ot_raw,
  output logic                    ut_raw,
  output logic                    oc_raw,
  output logic                    chg_det,
  output logic                    scan_done,
  output logic                    adc_err,
  output logic                    scan_ovr
`ifdef BMS_FLAG_MINMAX_EN
  ,
  output logic [ADC_W-1:0]        vmax_o,
  output logic [ADC_W-1:0]        vmin_o,
  output logic [ADC_W-1:0]        tmax_o,
  output logic [ADC_W-1:0]        tmin_o,
  output logic signed [ADC_W-1:0] i_o
`endif
);

  localparam int TMR_W  = $clog2(SCAN_PERIOD);
  localparam int WAIT_W = $clog2(ACK_TMO + 1);

  localparam logic [TMR_W-1:0]  c_tmr_last  = TMR_W'(SCAN_PERIOD - 1);
  localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(ACK_TMO - 1);
  localparam logic [CH_W-1:0]   c_chan_last = CH_W'(N_CELLS + N_TEMP);
  localparam logic [ADC_W-1:0]  c_ov_set    = ADC_W'(OV_SET);
  localparam logic [ADC_W-1:0]  c_ov_clr    = ADC_W'(OV_CLR);
  localparam logic [ADC_W-1:0]  c_uv_set    = ADC_W'(UV_SET);
  localparam logic [ADC_W-1:0]  c_uv_clr    = ADC_W'(UV_CLR);
  localparam logic [ADC_W-1:0]  c_ot_set    = ADC_W'(OT_SET);
  localparam logic [ADC_W-1:0]  c_ot_clr    = ADC_W'(OT_CLR);
  localparam logic [ADC_W-1:0]  c_ut_set    = ADC_W'(UT_SET);
  localparam logic [ADC_W-1:0]  c_ut_clr    = ADC_W'(UT_CLR);
  localparam logic [ADC_W-1:0]  c_oc_set    = ADC_W'(OC_SET);
  localparam logic [ADC_W-1:0]  c_oc_clr    = ADC_W'(OC_CLR);
  localparam logic signed [ADC_W-1:0] c_i_min   = {1'b1, {(ADC_W-1){1'b0}}};
  localparam logic [ADC_W-1:0]        c_i_max   = {1'b0, {(ADC_W-1){1'b1}}};
  localparam logic signed [ADC_W-1:0] c_chg_neg = ADC_W'(-CHG_TH);

  state_t                  state_q, state_d;
  logic [TMR_W-1:0]        timer_q, timer_d;
  logic                    pend_q, pend_d;
  logic                    req_q, req_d;
  logic [CH_W-1:0]         chan_q, chan_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic [ADC_W-1:0]        vmax_q, vmax_d, vmin_q, vmin_d;
  logic [ADC_W-1:0]        tmax_q, tmax_d, tmin_q, tmin_d;
  logic signed [ADC_W-1:0] cur_q, cur_d;
  logic                    err_q, err_d, done_q, done_d;
  logic                    ovr_q, ovr_d, chg_q, chg_d;

  logic [ADC_W-1:0] cur_abs;
  logic             wrap, start, tmo, last_chan, commit;
  logic [4:0]       set_cond, clr_cond, flags;

  assign wrap      = (timer_q == c_tmr_last);
  assign start     = (state_q == IDLE) && pend_q && en;
  assign tmo       = req_q && !adc_ack && (wait_q == c_wait_last);
  assign last_chan = (chan_q == c_chan_last);
  assign commit    = (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = REQ;
      REQ: begin
        if (req_q && adc_ack && last_chan)
          state_d = DONE;
        else if (tmo)
          state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    timer_d = wrap ? '0 : timer_q + TMR_W'(1);
    pend_d  = (pend_q && !start) || wrap;
    req_d   = req_q;
    chan_d  = chan_q;
    wait_d  = wait_q;
    vmax_d  = vmax_q;
    vmin_d  = vmin_q;
    tmax_d  = tmax_q;
    tmin_d  = tmin_q;
    cur_d   = cur_q;
    err_d   = tmo;
    done_d  = commit;
    ovr_d   = wrap && (state_q != IDLE);
    chg_d   = commit ? (cur_q < c_chg_neg) : chg_q;
    if (start) begin
      req_d  = 1'b1;
      chan_d = '0;
      wait_d = '0;
      vmax_d = '0;
      vmin_d = '1;
      tmax_d = '0;
      tmin_d = '1;
      cur_d  = '0;
    end else if (state_q == REQ) begin
      // req_q low in REQ is the one-cycle gap between channels
      if (!req_q) begin
        req_d  = 1'b1;
        wait_d = '0;
      end else if (adc_ack) begin
        req_d  = 1'b0;
        wait_d = '0;
        if (!last_chan)
          chan_d = chan_q + CH_W'(1);
        case (chan_kind(int'(chan_q), N_CELLS, N_TEMP))
          CH_CELL: begin
            if (adc_data > vmax_q) vmax_d = adc_data;
            if (adc_data < vmin_q) vmin_d = adc_data;
          end
          CH_TEMP: begin
            if (adc_data > tmax_q) tmax_d = adc_data;
            if (adc_data < tmin_q) tmin_d = adc_data;
          end
          default: cur_d = $signed(adc_data);
        endcase
      end else if (tmo) begin
        req_d = 1'b0;
      end else begin
        wait_d = wait_q + WAIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      pend_q  <= 1'b1;
      req_q   <= 1'b0;
      chan_q  <= '0;
      wait_q  <= '0;
      vmax_q  <= '0;
      vmin_q  <= '0;
      tmax_q  <= '0;
      tmin_q  <= '0;
      cur_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      pend_q  <= pend_d;
      req_q   <= req_d;
      chan_q  <= chan_d;
      wait_q  <= wait_d;
      vmax_q  <= vmax_d;
      vmin_q  <= vmin_d;
      tmax_q  <= tmax_d;
      tmin_q  <= tmin_d;
      cur_q   <= cur_d;
      err_q   <= err_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      chg_q   <= chg_d;
    end
  end

  // Most negative code has no positive twin; clamp it to full scale.
  always_comb begin
    if (cur_q == c_i_min)
      cur_abs = c_i_max;
    else if (cur_q[ADC_W-1])
      cur_abs = ADC_W'(-cur_q);
    else
      cur_abs = cur_q;
  end

  assign set_cond = {vmax_q >= c_ov_set, vmin_q <= c_uv_set, tmax_q >= c_ot_set,
                     tmin_q <= c_ut_set, cur_abs >= c_oc_set};
  assign clr_cond = {vmax_q <= c_ov_clr, vmin_q >= c_uv_clr, tmax_q <= c_ot_clr,
                     tmin_q >= c_ut_clr, cur_abs <= c_oc_clr};

  for (genvar g = 0; g < 5; g++) begin : g_flag
    bms_hyst_flag u_flag (
      .clk      (clk),
      .rst_n    (rst_n),
      .commit   (commit),
      .set_cond (set_cond[g]),
      .clr_cond (clr_cond[g]),
      .flag     (flags[g])
    );
  end

  assign {ov_raw, uv_raw, ot_raw, ut_raw, oc_raw} = flags;
  assign adc_req   = req_q;
  assign adc_chan  = chan_q;
  assign chg_det   = chg_q;
  assign scan_done = done_q;
  assign adc_err   = err_q;
  assign scan_ovr  = ovr_q;

`ifdef BMS_FLAG_MINMAX_EN
  logic [ADC_W-1:0]        mm_vmax_q, mm_vmax_d, mm_vmin_q, mm_vmin_d;
  logic [ADC_W-1:0]        mm_tmax_q, mm_tmax_d, mm_tmin_q, mm_tmin_d;
  logic signed [ADC_W-1:0] mm_i_q, mm_i_d;

  always_comb begin
    mm_vmax_d = commit ? vmax_q : mm_vmax_q;
    mm_vmin_d = commit ? vmin_q : mm_vmin_q;
    mm_tmax_d = commit ? tmax_q : mm_tmax_q;
    mm_tmin_d = commit ? tmin_q : mm_tmin_q;
    mm_i_d    = commit ? cur_q  : mm_i_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_vmax_q <= '0;
      mm_vmin_q <= '0;
      mm_tmax_q <= '0;
      mm_tmin_q <= '0;
      mm_i_q    <= '0;
    end else begin
      mm_vmax_q <= mm_vmax_d;
      mm_vmin_q <= mm_vmin_d;
      mm_tmax_q <= mm_tmax_d;
      mm_tmin_q <= mm_tmin_d;
      mm_i_q    <= mm_i_d;
    end
  end

  assign vmax_o = mm_vmax_q;
  assign vmin_o = mm_vmin_q;
  assign tmax_o = mm_tmax_q;
  assign tmin_o = mm_tmin_q;
  assign i_o    = mm_i_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bms_flag_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bms_flag_gen : directed, table-driven bench for bms_flag_gen.           |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
module tb_bms_flag_gen;

  localparam int SP    = 1000;
  localparam int ADC_W = 12;
  localparam int NV    = 23;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, en, adc_req, adc_ack, chg_det, scan_done, adc_err, scan_ovr;
  logic              ov_raw, uv_raw, ot_raw, ut_raw, oc_raw;
  logic [2:0]        adc_chan;
  logic [ADC_W-1:0]  adc_data;
  logic              en2, adc_req2, adc_ack2, chg2, done2, err2, ovr2;
  logic              ov2, uv2, ot2, ut2, oc2;
  logic [2:0]        adc_chan2;
  logic [ADC_W-1:0]  adc_data2;
  logic [5:0]        flg;
`ifdef BMS_FLAG_MINMAX_EN
  logic [ADC_W-1:0]        vmax_o, vmin_o, tmax_o, tmin_o, vmax2, vmin2, tmax2, tmin2;
  logic signed [ADC_W-1:0] i_o, i2;
`endif

  assign flg = {ov_raw, uv_raw, ot_raw, ut_raw, oc_raw, chg_det};

  bms_flag_gen #(.SCAN_PERIOD(SP)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .adc_req(adc_req), .adc_chan(adc_chan),
    .adc_ack(adc_ack), .adc_data(adc_data), .ov_raw(ov_raw), .uv_raw(uv_raw),
    .ot_raw(ot_raw), .ut_raw(ut_raw), .oc_raw(oc_raw), .chg_det(chg_det),
    .scan_done(scan_done), .adc_err(adc_err), .scan_ovr(scan_ovr)
`ifdef BMS_FLAG_MINMAX_EN
    , .vmax_o(vmax_o), .vmin_o(vmin_o), .tmax_o(tmax_o), .tmin_o(tmin_o), .i_o(i_o)
`endif
  );

  bms_flag_gen #(.SCAN_PERIOD(20)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en2), .adc_req(adc_req2), .adc_chan(adc_chan2),
    .adc_ack(adc_ack2), .adc_data(adc_data2), .ov_raw(ov2), .uv_raw(uv2),
    .ot_raw(ot2), .ut_raw(ut2), .oc_raw(oc2), .chg_det(chg2),
    .scan_done(done2), .adc_err(err2), .scan_ovr(ovr2)
`ifdef BMS_FLAG_MINMAX_EN
    , .vmax_o(vmax2), .vmin_o(vmin2), .tmax_o(tmax2), .tmin_o(tmin2), .i_o(i2)
`endif
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc++;

  // ADC models: ack LAT negedges after the request is first seen.
  logic [ADC_W-1:0] ch_val [7];
  int  lat1 = 3, cnt1 = 0, cnt2 = 0, hold_ch = 4;
  bit  hold_en = 0;
  always @(negedge clk) begin
    adc_ack = 1'b0;
    if (adc_req && !(hold_en && int'(adc_chan) == hold_ch)) begin
      if (cnt1 == lat1) begin
        adc_ack = 1'b1; adc_data = ch_val[adc_chan]; cnt1 = 0;
      end else cnt1++;
    end else cnt1 = 0;
  end
  always @(negedge clk) begin
    adc_ack2 = 1'b0;
    if (adc_req2) begin
      if (cnt2 == 5) begin
        adc_ack2 = 1'b1; adc_data2 = '0; cnt2 = 0;
      end else cnt2++;
    end else cnt2 = 0;
  end

  bit   rec = 0, prev_req = 0;
  logic [2:0] chq [$];
  int   last_start = 0;
  always @(negedge clk) begin
    if (adc_req && !prev_req) begin
      if (rec) chq.push_back(adc_chan);
      if (adc_chan == 3'd0) last_start = cyc;
    end
    prev_req = adc_req;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok, output int at);
    ok = 0; at = 0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(negedge clk);
      if (scan_done) begin ok = 1; at = cyc; end
    end
  endtask

  typedef struct packed {
    logic [6:0][ADC_W-1:0] v;
    logic [5:0]            e;   // {ov,uv,ot,ut,oc,chg}
  } vec_t;
  vec_t vecs [NV];

  function automatic vec_t mk(int c0, int c1, int c2, int c3, int t0, int t1, int i,
                              logic [5:0] e);
    vec_t r;
    r.v[0] = 12'(c0); r.v[1] = 12'(c1); r.v[2] = 12'(c2); r.v[3] = 12'(c3);
    r.v[4] = 12'(t0); r.v[5] = 12'(t1); r.v[6] = 12'(i);
    r.e = e;
    return r;
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok, seen;
    int at, prev_at, n, ovr_n, abort_start, dn;
    logic [ADC_W-1:0] m;

    vecs[0]  = mk(3300, 3300, 3300, 3300, 2000, 2000,   100, 6'b000000);
    vecs[1]  = mk(3300, 3300, 3700, 3300, 2000, 2000,   100, 6'b100000);
    vecs[2]  = mk(3300, 3300, 3600, 3300, 2000, 2000,   100, 6'b100000);
    vecs[3]  = mk(3300, 3300, 3500, 3300, 2000, 2000,   100, 6'b000000);
    vecs[4]  = mk(3300, 3686, 3300, 3300, 2000, 2000,   100, 6'b100000);
    vecs[5]  = mk(3300, 3563, 3300, 3300, 2000, 2000,   100, 6'b000000);
    vecs[6]  = mk(2458, 3300, 3300, 3300, 2000, 2000,   100, 6'b010000);
    vecs[7]  = mk(2500, 3300, 3300, 3300, 2000, 2000,   100, 6'b010000);
    vecs[8]  = mk(2580, 3300, 3300, 3300, 2000, 2000,   100, 6'b000000);
    vecs[9]  = mk(3300, 3300, 3300, 3300, 2000, 3000,   100, 6'b001000);
    vecs[10] = mk(3300, 3300, 3300, 3300, 2000, 2801,   100, 6'b001000);
    vecs[11] = mk(3300, 3300, 3300, 3300, 2000, 2800,   100, 6'b000000);
    vecs[12] = mk(3300, 3300, 3300, 3300,  800, 2000,   100, 6'b000100);
    vecs[13] = mk(3300, 3300, 3300, 3300,  999, 2000,   100, 6'b000100);
    vecs[14] = mk(3300, 3300, 3300, 3300, 1000, 2000,   100, 6'b000000);
    vecs[15] = mk(3300, 3300, 3300, 3300, 2000, 2000, -2048, 6'b000011);
    vecs[16] = mk(3300, 3300, 3300, 3300, 2000, 2000,  1400, 6'b000010);
    vecs[17] = mk(3300, 3300, 3300, 3300, 2000, 2000,   -40, 6'b000000);
    vecs[18] = mk(3300, 3300, 3300, 3300, 2000, 2000,   -51, 6'b000001);
    vecs[19] = mk(3300, 3300, 3300, 3300, 2000, 2000,   -50, 6'b000000);
    vecs[20] = mk(3300, 3300, 3300, 3300, 2000, 2000,  1500, 6'b000010);
    vecs[21] = mk(3300, 3300, 3300, 3300, 2000, 2000, -1300, 6'b000001);
    vecs[22] = mk(3700, 2400, 3300, 3300, 3100,  700,  2047, 6'b111110);

    rst_n = 1'b0; en = 1'b0; en2 = 1'b0; adc_ack = 1'b0; adc_data = '0;
    adc_ack2 = 1'b0; adc_data2 = '0; prev_at = 0;
    for (int j = 0; j < 7; j++) ch_val[j] = vecs[0].v[j];
    repeat (3) @(negedge clk);
    chk("reset_outputs", {adc_req, flg, scan_done, adc_err, scan_ovr, adc_chan}, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_while_en_low", adc_req, 0);

    // Overrun on the short-period instance: back-to-back restart after DONE.
    en2 = 1'b1; ovr_n = 0; seen = 0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(negedge clk);
      if (ovr2) ovr_n++;
      if (done2) begin
        seen = 1;
        chk("ovr_req_at_done", adc_req2, 0);
        @(negedge clk);
        chk("ovr_restart_next_cycle", adc_req2, 1);
      end
    end
    chk("ovr_scan_done_seen", seen, 1);
    chk("ovr_pulse_seen", ovr_n > 0, 1);
    en2 = 1'b0;

    rec = 1;
    for (int k = 0; k < NV; k++) begin
      for (int j = 0; j < 7; j++) ch_val[j] = vecs[k].v[j];
      if (k == 0) en = 1'b1;
      wait_done(2 * SP, ok, at);
      chk($sformatf("scan_done_v%0d", k), ok, 1);
      chk($sformatf("flags_v%0d", k), flg, vecs[k].e);
`ifdef BMS_FLAG_MINMAX_EN
      m = '0;
      for (int j = 0; j < 4; j++) if (vecs[k].v[j] > m) m = vecs[k].v[j];
      chk($sformatf("vmax_o_v%0d", k), vmax_o, m);
`endif
      if (k == 0) begin
        rec = 0;
        chk("chan_count", chq.size(), 7);
        for (int j = 0; j < chq.size() && j < 7; j++)
          chk($sformatf("chan_seq%0d", j), chq[j], j);
      end
      if (k == 2) chk("scan_period", at - prev_at, SP);
      prev_at = at;
    end

    // Timeout: withhold ack on channel 4.
    hold_en = 1; hold_ch = 4; n = 0;
    while (!(adc_req && adc_chan == 3'd4) && n < 3 * SP) begin @(negedge clk); n++; end
    chk("tmo_req_chan4", adc_req && adc_chan == 3'd4, 1);
    n = 0;
    while (adc_req && n < 400) begin @(negedge clk); n++; end
    chk("tmo_req_cycles", n, 256);
    chk("tmo_err_pulse", adc_err, 1);
    chk("tmo_flags_held", flg, 6'b111110);
    abort_start = last_start;
    hold_en = 0;
    @(negedge clk);
    chk("tmo_err_one_cycle", adc_err, 0);
    n = 0; dn = 0;
    while (last_start == abort_start && n < 2 * SP) begin
      @(negedge clk); n++;
      if (scan_done) dn++;
    end
    chk("tmo_no_scan_done", dn, 0);
    chk("tmo_next_start", last_start - abort_start, SP);
    wait_done(2 * SP, ok, at);
    chk("post_tmo_scan_done", ok, 1);
    chk("post_tmo_flags", flg, 6'b111110);

    // en dropped mid-scan: scan finishes, nothing new starts.
    n = 0;
    while (!(adc_req && adc_chan == 3'd2) && n < 2 * SP) begin @(negedge clk); n++; end
    chk("en_mid_scan_chan2", adc_req && adc_chan == 3'd2, 1);
    en = 1'b0;
    wait_done(2 * SP, ok, at);
    chk("en_low_scan_done", ok, 1);
    n = 0;
    for (int k = 0; k < 2 * SP + 50; k++) begin @(negedge clk); if (adc_req) n++; end
    chk("en_low_no_req", n, 0);
    chk("en_low_flags_hold", flg, 6'b111110);

    // Asynchronous reset in the middle of a request.
    en = 1'b1; n = 0;
    while (!adc_req && n < 10) begin @(negedge clk); n++; end
    chk("rst_req_active", adc_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", adc_req, 0);
    chk("rst_async_flags", flg, 0);
    #20;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bms_flag_gen.md
Name: bms_flag_gen

Overview:
Front-end monitor that produces the raw protection flags (ov/uv/ot/ut/oc) and a charge-direction indicator for the BMS protection FSM. It initiates conversions on the ADC sequencer over a req/ack handshake and scans all cell voltages, temperature sensors and pack current once per scan period. It aggregates each scan, applies set/clear hysteresis, and commits all flags atomically at scan end.

Parameters:
N_CELLS, 4, number of cell-voltage channels
N_TEMP, 2, number of temperature channels
ADC_W, 12, ADC sample width
SCAN_PERIOD, 10000, cycles between scan starts (>= 2)
ACK_TMO, 256, max cycles adc_req may wait for adc_ack
OV_SET / OV_CLR, 3686 / 3563, over-voltage set / clear codes (unsigned)
UV_SET / UV_CLR, 2458 / 2580, under-voltage set / clear codes
OT_SET / OT_CLR, 3000 / 2800, over-temp set / clear codes
UT_SET / UT_CLR, 800 / 1000, under-temp set / clear codes
OC_SET / OC_CLR, 1500 / 1300, over-current set / clear on |I|
CHG_TH, 50, charging detected when I < -CHG_TH

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
en  in  1  scan enable
adc_req  out  1  conversion request
adc_chan  out  CH_W=$clog2(N_CELLS+N_TEMP+1)  channel being requested
adc_ack  in  1  one-cycle conversion-complete strobe
adc_data  in  ADC_W  sample, valid with adc_ack
ov_raw, uv_raw, ot_raw, ut_raw, oc_raw  out  1 each  hysteretic flags
chg_det  out  1  charging direction
scan_done  out  1  one-cycle pulse on flag commit
adc_err  out  1  one-cycle pulse on ack timeout
scan_ovr  out  1  one-cycle pulse when a scan exceeds SCAN_PERIOD

Behaviour:
- Reset values: all outputs 0, state IDLE, period timer 0, start_pending=1.
- Channel order:
  - 0..N_CELLS-1: cells, unsigned.
  - N_CELLS..N_CELLS+N_TEMP-1: temps, unsigned, larger code = hotter.
  - Last channel: current, signed two's complement, negative = charge.
- Period timer runs free from reset and wraps at SCAN_PERIOD-1. Wrap sets start_pending.
- States:
  - IDLE: if start_pending && en, clear start_pending and accumulators, go to REQ with chan=0.
  - REQ:
    - adc_req=1, adc_chan stable.
    - On the edge that samples adc_ack=1, accumulate adc_data. adc_req is low the following cycle.
    - If this was the last channel, go to DONE; else chan+1 and REQ again (req reasserts one cycle after drop).
  - DONE (one cycle): the next edge updates all flags and chg_det together and asserts scan_done for one cycle, then go to IDLE.
- Latency: flags visible 2 edges after the last ack sample.
- adc_ack is ignored when adc_req=0.
- Timeout:
  - The wait counter counts cycles with adc_req=1.
  - If no ack by the ACK_TMO-th cycle, drop adc_req, pulse adc_err, abort the scan and return to IDLE.
  - Flags are held and scan_done is not pulsed.
- Accumulation per scan:
  - vmax/vmin over cells, tmax/tmin over temps.
  - |I| saturates: -2^(ADC_W-1) maps to 2^(ADC_W-1)-1.
- Hysteresis at commit (otherwise hold):
  - ov: set if vmax>=OV_SET, clear if vmax<=OV_CLR.
  - uv: set if vmin<=UV_SET, clear if vmin>=UV_CLR.
  - ot: set if tmax>=OT_SET, clear if tmax<=OT_CLR.
  - ut: set if tmin<=UT_SET, clear if tmin>=UT_CLR.
  - oc: set if |I|>=OC_SET, clear if |I|<=OC_CLR.
  - chg_det = (I < -CHG_TH), no hysteresis.
- Overrun: if the timer wraps while not in IDLE, pulse scan_ovr. start_pending stays set, so the next scan begins immediately after DONE or abort.
- en low: an active scan completes normally; no new scan starts; flags hold.
- Reset mid-scan: adc_req drops asynchronously; all state returns to reset values.

Optional Feature:
BMS_FLAG_MINMAX_EN: adds outputs vmax_o, vmin_o [ADC_W], tmax_o, tmin_o [ADC_W] and i_o [ADC_W] signed. They are registered on the same edge as scan_done, reset 0, and hold on timeout. Without the macro these ports and registers do not exist; flag behaviour is identical either way.

Decomposition:
- Package bms_mon_pkg:
  - state enum {IDLE, REQ, DONE}.
  - channel-kind constants (CH_CELL, CH_TEMP, CH_CUR).
  - Function chan_kind(idx).
  - Default threshold localparams.
- Sub-module bms_hyst_flag (inputs set_cond, clr_cond, commit; output flag register, async reset 0), instantiated five times.

Test Plan:
- Nominal: cells 3300, temps 2000, I=+100, ack 3 cycles after req -> all flags 0, chg_det 0, scan_done once per 10000 cycles, adc_chan sequence 0..6.
- OV hysteresis: cell2=3700 -> ov_raw=1 at scan_done; next scan cell2=3600 -> stays 1; next scan 3500 -> 0.
- Current: I=-2048 -> oc_raw=1, chg_det=1; I=-40 -> oc_raw=0, chg_det=0; I=1400 after oc set -> oc holds 1.
- Timeout: withhold ack on chan 4 -> adc_req low and adc_err pulse exactly 256 cycles after req rise, no scan_done, flags unchanged, next scan starts at next period.
- Overrun: SCAN_PERIOD=20, ack latency 5 -> scan_ovr pulses, next scan begins the cycle after DONE.
- Reset/en: assert rst_n low mid-REQ -> adc_req 0 immediately, flags 0. en low mid-scan -> scan finishes with scan_done, then no further adc_req.
